// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared types and helpers for the burst main memory.
//   state_e  : controller FSM states
//   lat_w    : latency-counter width for a given DELAY_MEM
//   line_idx : byte address -> line number (caller truncates to index width)
//   page_num : byte address -> page number (caller truncates)
package burst_mem_pkg;

  typedef enum logic [1:0] {IDLE, LATENCY, BURST, TURN} state_e;

  function automatic int unsigned lat_w(input int unsigned delay_mem);
    return $clog2(delay_mem + 1);
  endfunction

  function automatic logic [31:0] line_idx(input logic [31:0] addr, input int unsigned line_bytes_log2);
    return addr >> line_bytes_log2;
  endfunction

  function automatic logic [31:0] page_num(input logic [31:0] addr, input int unsigned page_log2);
    return addr >> page_log2;
  endfunction

endpackage

// File: rtl/burst_mem_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this round
//   gnt : one-hot grant of the first requester at or after ptr
//   vld : any request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    vld = found;
  end

endmodule

// File: rtl/burst_mem_arb.sv
// burst_mem_arb: multi-port burst main memory with round-robin arbitration.
//   clk, rst_n          : clock, synchronous active-low reset
//   mem_read/mem_write  : per-port request, held until the burst ends
//   mem_address         : per-port byte address, held for the access
//   mem_wdata/_byte_enable : per-port write beat and strobes
//   mem_resp            : one-hot beat strobe of the granted port
//   mem_rdata           : registered read beat, shared by all ports
//   pm_error            : sticky per-port protocol error
// Optional MEM_ERR_CHECK_EN enables protocol checking; otherwise pm_error = 0.
// Storage is one BW-bit word per beat; INIT_FILE images use that layout.
// DEPTH_LINES and BURST_LEN are assumed powers of two >= 2.
module burst_mem_arb import burst_mem_pkg::*; #(
  parameter int    NUM_PORTS      = 2,
  parameter int    LINE_WIDTH     = 256,
  parameter int    BURST_LEN      = 8,
  parameter int    DEPTH_LINES    = 1024,
  parameter int    DELAY_MEM      = 10,
  parameter int    DELAY_PAGE_HIT = 4,
  parameter int    PAGE_SIZE      = 2048,
  parameter string INIT_FILE      = "",
  localparam int   BW             = LINE_WIDTH / BURST_LEN
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 mem_read,
  input  logic [NUM_PORTS-1:0]                 mem_write,
  input  logic [NUM_PORTS-1:0][31:0]           mem_address,
  input  logic [NUM_PORTS-1:0][BW-1:0]         mem_wdata,
  input  logic [NUM_PORTS-1:0][BW/8-1:0]       mem_byte_enable,
  output logic [NUM_PORTS-1:0]                 mem_resp,
  output logic [BW-1:0]                        mem_rdata,
  output logic [NUM_PORTS-1:0]                 pm_error
);

  localparam int NB  = BW / 8;
  localparam int LB  = $clog2(LINE_WIDTH / 8);
  localparam int DL  = $clog2(DEPTH_LINES);
  localparam int BL  = $clog2(BURST_LEN);
  localparam int PB  = $clog2(PAGE_SIZE);
  localparam int PGW = 32 - PB;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW  = lat_w(DELAY_MEM);

  logic [BW-1:0] mem [DEPTH_LINES*BURST_LEN];

  state_e          state_q, state_d;
  logic [PW-1:0]   gnt_q, gnt_d, rr_q, rr_d, gidx;
  logic            wr_q, wr_d, page_vld_q, page_vld_d, hit;
  logic [DL-1:0]   line_q, line_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BL-1:0]   beat_q, beat_d;
  logic [PGW-1:0]  page_q, page_d, new_page;
  logic [BW-1:0]   rdata_q, rdata_d;
  logic [31:0]     sel_addr;
  logic [NUM_PORTS-1:0] cand, arb_gnt;
  logic            arb_vld, acc_err, we;

`ifdef MEM_ERR_CHECK_EN
  logic [31:0]          addr_q, addr_d;
  logic [NUM_PORTS-1:0] err_q, err_d, both;

  // Granted port must hold its op and address from grant to last beat.
  always_comb begin
    both    = mem_read & mem_write;
    cand    = mem_read ^ mem_write;
    acc_err = 1'b0;
    if (state_q == LATENCY || state_q == BURST)
      acc_err = (wr_q ? (!mem_write[gnt_q] || mem_read[gnt_q])
                      : (!mem_read[gnt_q]  || mem_write[gnt_q]))
                || (mem_address[gnt_q] != addr_q);
    addr_d = (state_q == IDLE && arb_vld) ? sel_addr : addr_q;
    err_d  = err_q;
    if (acc_err)         err_d = err_d | (NUM_PORTS'(1) << gnt_q);
    if (state_q == IDLE) err_d = err_d | both;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      err_q  <= '0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign pm_error = err_q;
`else
  assign cand     = mem_read | mem_write;
  assign acc_err  = 1'b0;
  assign pm_error = '0;
`endif

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
    .req (cand),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (arb_gnt[i]) gidx = PW'(i);
  end

  assign sel_addr = mem_address[gidx];
  assign new_page = PGW'(page_num(sel_addr, PB));
  assign hit      = page_vld_q && (page_q == new_page);

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      wr_q       <= 1'b0;
      line_q     <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      rr_q       <= '0;
      page_q     <= '0;
      page_vld_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      rr_q       <= rr_d;
      page_q     <= page_d;
      page_vld_q <= page_vld_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next state. The counter is loaded with delay-1 so that the edge
  // that sees zero is exactly grant+delay, where mem_resp rises.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    rr_d       = rr_q;
    page_d     = page_q;
    page_vld_d = page_vld_q;
    case (state_q)
      IDLE: if (arb_vld) begin
        gnt_d      = gidx;
        wr_d       = mem_write[gidx] & ~mem_read[gidx];  // read wins on both
        line_d     = DL'(line_idx(sel_addr, LB));
        cnt_d      = hit ? CW'(DELAY_PAGE_HIT - 1) : CW'(DELAY_MEM - 1);
        page_d     = new_page;
        page_vld_d = 1'b1;
        rr_d       = (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + PW'(1);
        state_d    = LATENCY;
      end
      LATENCY: begin
        if (acc_err)            state_d = TURN;
        else if (cnt_q == '0) begin
          state_d = BURST;
          beat_d  = '0;
        end else                cnt_d = cnt_q - CW'(1);
      end
      BURST: begin
        if (acc_err || beat_q == BL'(BURST_LEN - 1)) state_d = TURN;
        else beat_d = beat_q + BL'(1);
      end
      default: state_d = IDLE;
    endcase
    // Registered read: fetch the beat that will be presented next cycle.
    rdata_d = rdata_q;
    if (state_d == BURST && !wr_d) rdata_d = mem[{line_q, beat_d}];
  end

  // Output decode
  always_comb begin
    mem_resp = '0;
    if (state_q == BURST) mem_resp[gnt_q] = 1'b1;
  end

  assign mem_rdata = rdata_q;

  // A beat flagged as erroneous is not written; earlier beats stay.
  assign we = (state_q == BURST) && wr_q && !acc_err && rst_n;

  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < NB; b++)
        if (mem_byte_enable[gnt_q][b])
          mem[{line_q, beat_q}][b*8 +: 8] <= mem_wdata[gnt_q][b*8 +: 8];
  end

endmodule

// File: tb/tb_burst_mem_arb.sv
// tb_burst_mem_arb: directed checks of burst_mem_arb at default parameters.
module tb_burst_mem_arb;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mem_read, mem_write, mem_resp, pm_error;
  logic [1:0][31:0] mem_address, mem_wdata;
  logic [1:0][3:0]  mem_byte_enable;
  logic [31:0]      mem_rdata;

  int n_chk = 0, n_fail = 0;
  logic [31:0] wbuf[8], rbuf[8], expl[8];
  logic [3:0]  bebuf[8];
  int lat;

  always #5 clk = ~clk;

  burst_mem_arb dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .pm_error(pm_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_read = '0; mem_write = '0; mem_byte_enable = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated access from port p; lat = edges from grant to first beat.
  task automatic access(input int p, input bit wr, input logic [31:0] addr, output int l);
    int edges, beat;
    edges = 0; beat = 0; l = -1;
    mem_read[p] = !wr; mem_write[p] = wr; mem_address[p] = addr;
    while (beat < 8 && edges < 100) begin
      @(posedge clk); #1; edges++;
      if (mem_resp[p]) begin
        if (beat == 0) l = edges - 1;
        rbuf[beat] = mem_rdata;
        mem_wdata[p] = wbuf[beat];
        mem_byte_enable[p] = bebuf[beat];
        beat++;
      end
    end
    chk("beats", 64'(beat), 64'd8);
    @(posedge clk); #1;
    chk("resp_drop", 64'(mem_resp), 64'd0);
    mem_read[p] = 1'b0; mem_write[p] = 1'b0; mem_byte_enable[p] = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    int first[2], nb[2], ovl;
    mem_address = '0; mem_wdata = '0;
    do_reset();
    chk("rst_resp", 64'(mem_resp), 64'd0);
    chk("rst_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_err", 64'(pm_error), 64'd0);

    // Full write then page-hit read from the other port
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 32'hA0 + 32'(i); bebuf[i] = 4'hF; expl[i] = 32'hA0 + 32'(i);
    end
    access(0, 1'b1, 32'h100, lat);
    chk("wr_lat_miss", 64'(lat), 64'd10);
    access(1, 1'b0, 32'h100, lat);
    chk("rd_lat_hit", 64'(lat), 64'd4);
    for (int i = 0; i < 8; i++) chk($sformatf("rd_beat%0d", i), 64'(rbuf[i]), 64'(expl[i]));

    // Partial strobe on beat 3 only
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h5555_5555; bebuf[i] = 4'h0; end
    wbuf[3] = 32'h5555_55FF; bebuf[3] = 4'h1; expl[3] = 32'h0000_00FF;
    access(0, 1'b1, 32'h100, lat);
    for (int i = 0; i < 8; i++) bebuf[i] = 4'h0;
    access(1, 1'b0, 32'h100, lat);
    for (int i = 0; i < 8; i++) chk($sformatf("part_beat%0d", i), 64'(rbuf[i]), 64'(expl[i]));

    // Simultaneous requests with rr_ptr = 0
    do_reset();
    first = '{0, 0}; nb = '{0, 0}; ovl = 0;
    mem_address[0] = 32'h100; mem_address[1] = 32'h104; mem_read = 2'b11;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (&mem_resp) ovl++;
      for (int p = 0; p < 2; p++) begin
        if (mem_resp[p]) begin
          if (first[p] == 0) first[p] = e;
          if (p == 1 && nb[1] < 8) rbuf[nb[1]] = mem_rdata;
          nb[p]++;
        end else if (nb[p] == 8) mem_read[p] = 1'b0;
      end
    end
    chk("rr_overlap", 64'(ovl), 64'd0);
    chk("rr_p0_first", 64'(first[0]), 64'd11);
    chk("rr_p1_first", 64'(first[1]), 64'd25);
    chk("rr_p0_beats", 64'(nb[0]), 64'd8);
    chk("rr_p1_beats", 64'(nb[1]), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_p1_beat%0d", i), 64'(rbuf[i]), 64'(expl[i]));

    // Page tracking: page 0 is open from the previous bursts
    access(0, 1'b0, 32'h0, lat);
    chk("pg_0_hit", 64'(lat), 64'd4);
    access(0, 1'b0, 32'h800, lat);
    chk("pg_800_miss", 64'(lat), 64'd10);
    access(0, 1'b0, 32'h820, lat);
    chk("pg_820_hit", 64'(lat), 64'd4);

    // Reset during beat 4 of a page-hit read
    nb[0] = 0;
    mem_address[0] = 32'h820; mem_read[0] = 1'b1;
    for (int e = 0; e < 100 && nb[0] < 5; e++) begin
      @(posedge clk); #1;
      if (mem_resp[0]) nb[0]++;
    end
    chk("rst_mid_beats", 64'(nb[0]), 64'd5);
    rst_n = 1'b0; mem_read = '0;
    @(posedge clk); #1;
    chk("rst_mid_resp", 64'(mem_resp), 64'd0);
    chk("rst_mid_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_mid_err", 64'(pm_error), 64'd0);
    rst_n = 1'b1;
    access(0, 1'b0, 32'h820, lat);
    chk("rst_reopen_miss", 64'(lat), 64'd10);

`ifdef MEM_ERR_CHECK_EN
    // Address change in beat 2 of a read; port 1 is waiting
    do_reset();
    nb = '{0, 0}; first = '{0, 0};
    mem_address[0] = 32'h100; mem_address[1] = 32'h100; mem_read = 2'b11;
    for (int e = 0; e < 100 && nb[0] < 3; e++) begin
      @(posedge clk); #1;
      if (mem_resp[0]) nb[0]++;
    end
    chk("err_beats", 64'(nb[0]), 64'd3);
    mem_address[0] = 32'h104;
    @(posedge clk); #1;
    chk("err_resp_drop", 64'(mem_resp), 64'd0);
    chk("err_flag", 64'(pm_error), 64'd1);
    mem_read[0] = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (mem_resp[1]) begin if (first[1] == 0) first[1] = e; nb[1]++; end
      else if (nb[1] == 8) mem_read[1] = 1'b0;
      if (mem_resp[0]) nb[0]++;
    end
    chk("err_p1_served", 64'(nb[1]), 64'd8);
    chk("err_p0_silent", 64'(nb[0]), 64'd3);
    chk("err_sticky", 64'(pm_error), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
